button_event_ctrl: RTL

//  Turns the debounced button/switch vector from the debouncer into a queued

---
 rtl/button_event_ctrl_pkg.sv | 22 ++
 rtl/button_event_ctrl_sfifo.sv | 52 +++++
 rtl/button_event_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/button_event_ctrl_pkg.sv
// Shared event codes and hold-timer state encodings for the button event controller.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EV_RELEASE = 2'b00,
    EV_PRESS   = 2'b01,
    EV_LONG    = 2'b10,
    EV_RPT     = 2'b11
  } ev_type_e;

  typedef enum logic [1:0] {
    HOLD_IDLE   = 2'b00,
    HOLD_ARMED  = 2'b01,
    HOLD_REPEAT = 2'b10
  } hold_state_e;

  // Down-counter reload value for a period of 2^lg clocks.
  function automatic logic [63:0] period_load(input int lg);
    return (64'd1 << lg) - 64'd1;
  endfunction

endpackage

// File: rtl/button_event_ctrl_sfifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is dropped
// unless a read frees a slot in the same cycle.
module sfifo #(
  parameter int BW     = 7,
  parameter int LGFLEN = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic [BW-1:0] i_data,
  input  logic          i_rd,
  output logic [BW-1:0] o_data,
  output logic          o_empty,
  output logic          o_drop
);

  localparam int DEPTH = 1 << LGFLEN;

  logic [BW-1:0]   mem_q [DEPTH];
  logic [LGFLEN:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN:0] rd_ptr_q, rd_ptr_d;
  logic            full;
  logic            do_rd;
  logic            do_wr;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[LGFLEN-1:0] == rd_ptr_q[LGFLEN-1:0])
                && (wr_ptr_q[LGFLEN] != rd_ptr_q[LGFLEN]);
  assign do_rd   = i_rd && !o_empty;
  assign do_wr   = i_wr && (!full || do_rd);
  assign o_drop  = i_wr && !do_wr;
  assign o_data  = mem_q[rd_ptr_q[LGFLEN-1:0]];

  assign wr_ptr_d = do_wr ? wr_ptr_q + (LGFLEN+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_rd ? rd_ptr_q + (LGFLEN+1)'(1) : rd_ptr_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wr_ptr_q[LGFLEN-1:0]] <= i_data;
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Converts debounced button levels into a queue of press/release/long/repeat events.
// Hold FSM: IDLE | no button held | ARMED | waiting for long-press | REPEAT | emitting repeats
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int NIN    = 21,
  parameter int IW     = 5,
  parameter int LGFIFO = 4,
  parameter int LGHOLD = 24,
  parameter int LGRPT  = 22
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NIN-1:0]  i_debounced,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [IW+1:0]   o_event,
  input  logic            i_clr_overflow,
  output logic            o_overflow,
  output logic            o_int
);

  localparam int TW = (LGHOLD > LGRPT) ? LGHOLD : LGRPT;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(period_load(LGHOLD));
  localparam logic [TW-1:0] RPT_LOAD  = TW'(period_load(LGRPT));

  logic [NIN-1:0] r_prev_q;
  logic [NIN-1:0] pend_q, pend_d;
  logic [IW-1:0]  rr_q, rr_d;
  logic           ovf_q, ovf_d;

  logic           lo_vld, hi_vld, grant_vld;
  logic [IW-1:0]  lo_idx, hi_idx, grant_idx;
  logic [NIN-1:0] grant_mask;
  ev_type_e       grant_type;
  logic           press_grant;

  hold_state_e    hold_state_q;
  logic [TW-1:0]  timer_q;
  logic [IW-1:0]  hold_idx_q;
  logic           hreq_pend_q;
  ev_type_e       hreq_type_q;
  logic           hold_live;
  logic           hold_fire;
  ev_type_e       fire_type;
  ev_type_e       hreq_out_type;
  logic           hreq_wr;

  logic           fifo_wr;
  logic [IW+1:0]  fifo_wdata;
  logic           fifo_empty;
  logic           fifo_drop;

  // Round-robin: lowest pending index at or above rr, else the lowest overall.
  always_comb begin
    lo_vld = 1'b0;
    lo_idx = '0;
    hi_vld = 1'b0;
    hi_idx = '0;
    for (int i = NIN-1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lo_vld = 1'b1;
        lo_idx = IW'(i);
        if (IW'(i) >= rr_q) begin
          hi_vld = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
  end

  assign grant_vld   = lo_vld;
  assign grant_idx   = hi_vld ? hi_idx : lo_idx;
  assign grant_mask  = grant_vld ? (NIN'(1) << grant_idx) : '0;
  assign grant_type  = r_prev_q[grant_idx] ? EV_PRESS : EV_RELEASE;
  assign press_grant = grant_vld && r_prev_q[grant_idx];

  assign pend_d = (pend_q & ~grant_mask) | (i_debounced ^ r_prev_q);
  assign rr_d   = !grant_vld                  ? rr_q :
                  (grant_idx == IW'(NIN-1))   ? '0   :
                                                grant_idx + IW'(1);

  assign hold_live     = (hold_state_q != HOLD_IDLE) && r_prev_q[hold_idx_q];
  assign hold_fire     = hold_live && (timer_q == '0);
  assign fire_type     = (hold_state_q == HOLD_ARMED) ? EV_LONG : EV_RPT;
  assign hreq_out_type = hreq_pend_q ? hreq_type_q : fire_type;
  assign hreq_wr       = !grant_vld && hold_live && (hreq_pend_q || hold_fire);

  assign fifo_wr    = grant_vld || hreq_wr;
  assign fifo_wdata = grant_vld ? {grant_type, grant_idx} : {hreq_out_type, hold_idx_q};

  assign ovf_d = (ovf_q && !i_clr_overflow) || fifo_drop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev_q <= i_debounced;
      pend_q   <= '0;
      rr_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      r_prev_q <= i_debounced;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
    end
  end

  // A new press always retargets the shared timer; a waiting request from the
  // previous button is discarded with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_state_q <= HOLD_IDLE;
      timer_q      <= '0;
      hold_idx_q   <= '0;
      hreq_pend_q  <= 1'b0;
      hreq_type_q  <= EV_LONG;
    end else if (press_grant) begin
      hold_state_q <= HOLD_ARMED;
      hold_idx_q   <= grant_idx;
      timer_q      <= HOLD_LOAD;
      hreq_pend_q  <= 1'b0;
    end else if ((hold_state_q != HOLD_IDLE) && !r_prev_q[hold_idx_q]) begin
      hold_state_q <= HOLD_IDLE;
      hreq_pend_q  <= 1'b0;
    end else begin
      case (hold_state_q)
        HOLD_ARMED: begin
          if (timer_q == '0) begin
            hold_state_q <= HOLD_REPEAT;
            timer_q      <= RPT_LOAD;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        HOLD_REPEAT: begin
          if (timer_q == '0) timer_q <= RPT_LOAD;
          else               timer_q <= timer_q - TW'(1);
        end
        default: ;
      endcase
      if (hold_fire && grant_vld && !hreq_pend_q) begin
        hreq_pend_q <= 1'b1;
        hreq_type_q <= fire_type;
      end else if (hreq_wr) begin
        hreq_pend_q <= 1'b0;
      end
    end
  end

  sfifo #(
    .BW     (IW+2),
    .LGFLEN (LGFIFO)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (fifo_wr),
    .i_data  (fifo_wdata),
    .i_rd    (i_ready),
    .o_data  (o_event),
    .o_empty (fifo_empty),
    .o_drop  (fifo_drop)
  );

  assign o_valid    = !fifo_empty;
  assign o_int      = !fifo_empty;
  assign o_overflow = ovf_q;

endmodule
